// File: rtl/dmc_rx_frame_seq.sv
// dmc_rx_frame_seq
// Frame-level sequencer for one DMC decode channel. For each frame it walks the
// decoder through a sync phase, a data phase and a line-reset gap. It counts
// decoded data bits, runs a no-progress watchdog and reports each frame's
// completion (frame_done) or watchdog error (frame_err).
//
// Optional feature macro: DMC_SEQ_ERR_CNT_EN
//   defined   -> err_cnt is a saturating (255) count of watchdog errors,
//                cleared only by reset_n_period.
//   undefined -> err_cnt is tied to zero and no counter register exists.
//
// Handshake: start is a level request with no ready. It is sampled only in
// IDLE, so a level held high re-arms the block right after each frame.
// dbg_state exposes the one-hot FSM state for checkers.
module dmc_rx_frame_seq #(
    parameter int BIT_CNT_W  = 8,
    parameter int TMO_W      = 12,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_period,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BIT_CNT_W-1:0] cfg_data_bits,
    input  logic [TMO_W-1:0]     cfg_timeout,
    input  logic                 dec_early_receive_done,
    input  logic                 dec_bit_stb,
    output logic                 dec_enable,
    output logic                 dec_clk_or_data,
    output logic                 dec_line_rst_n,
    output logic                 busy,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [7:0]           err_cnt,
    output logic [3:0]           dbg_state
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SYNC = 4'b0010,
        DATA = 4'b0100,
        GAP  = 4'b1000
    } state_t;

    state_t             state;
    logic [TMO_W-1:0]   wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               done_pending;

    logic               in_active;
    logic               progress;
    logic               wd_expire;
    logic               last_bit;
    logic               sync_empty;
    logic               go_gap;
    logic               gap_pending;
    logic               gap_last;

    assign dbg_state = state;

    // Event decode for the current cycle; expiry yields to progress, abort
    // yields to expiry, and a completed frame yields to abort.
    always_comb begin
        in_active   = (state == SYNC) || (state == DATA);
        progress    = ((state == SYNC) && dec_early_receive_done) ||
                      ((state == DATA) && dec_bit_stb);
        wd_expire   = in_active && !progress && (cfg_timeout != '0) &&
                      (wd_cnt >= (cfg_timeout - TMO_W'(1)));
        last_bit    = (state == DATA) && dec_bit_stb &&
                      ((bit_cnt + BIT_CNT_W'(1)) == cfg_data_bits);
        sync_empty  = (state == SYNC) && dec_early_receive_done &&
                      (cfg_data_bits == '0);
        go_gap      = wd_expire || (in_active && abort) || sync_empty || last_bit;
        gap_pending = !wd_expire && !abort && (sync_empty || last_bit);
        gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    end

    // Frame FSM with all decoder-facing and status outputs registered.
    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            state           <= IDLE;
            dec_enable      <= 1'b0;
            dec_clk_or_data <= 1'b1;
            dec_line_rst_n  <= 1'b1;
            busy            <= 1'b0;
            bit_cnt         <= '0;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            wd_cnt          <= '0;
            gap_cnt         <= '0;
            done_pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= SYNC;
                        dec_enable      <= 1'b1;
                        dec_clk_or_data <= 1'b1;
                        busy            <= 1'b1;
                        bit_cnt         <= '0;
                        wd_cnt          <= '0;
                    end
                end
                SYNC, DATA: begin
                    // A strobe is a decoded bit even when abort lands with it.
                    if ((state == DATA) && dec_bit_stb) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    end
                    if (progress) begin
                        wd_cnt <= '0;
                    end else if (cfg_timeout != '0) begin
                        wd_cnt <= wd_cnt + TMO_W'(1);
                    end
                    if (go_gap) begin
                        state           <= GAP;
                        dec_enable      <= 1'b0;
                        dec_clk_or_data <= 1'b1;
                        dec_line_rst_n  <= 1'b0;
                        gap_cnt         <= '0;
                        done_pending    <= gap_pending;
                        frame_err       <= wd_expire;
                    end else if ((state == SYNC) && dec_early_receive_done) begin
                        state           <= DATA;
                        dec_clk_or_data <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state          <= IDLE;
                        dec_line_rst_n <= 1'b1;
                        busy           <= 1'b0;
                        frame_done     <= done_pending;
                        done_pending   <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state           <= IDLE;
                    dec_enable      <= 1'b0;
                    dec_clk_or_data <= 1'b1;
                    dec_line_rst_n  <= 1'b1;
                    busy            <= 1'b0;
                    done_pending    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMC_SEQ_ERR_CNT_EN
    // Saturating count of watchdog errors, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_n_period) begin
        if (!reset_n_period) begin
            err_cnt <= 8'd0;
        end else if (wd_expire && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule
